car_cmd_encoder: RTL and testbench

//  Command source for the tail-lamp/flow-LED controller: turns five raw push keys into the one-hot
//  4-bit drive code that controller consumes on its state_in port, replacing DIP switches.

---
 rtl/car_cmd_encoder_pkg.sv | 42 ++++
 rtl/car_cmd_encoder_if.sv | 13 +
 rtl/car_cmd_encoder_debounce.sv | 49 ++++
 rtl/car_cmd_encoder.sv | 127 ++++++++++++
 tb/tb_car_cmd_encoder.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/car_cmd_encoder_pkg.sv
// Shared definitions for the key-driven command encoder and the lamp controller
// that consumes its drive code.
package car_cmd_pkg;

    localparam int NUM_KEYS  = 5;
    localparam int KEY_GO    = 0;
    localparam int KEY_LEFT  = 1;
    localparam int KEY_RIGHT = 2;
    localparam int KEY_BACK  = 3;
    localparam int KEY_STOP  = 4;

    localparam logic [3:0] CODE_STOP  = 4'b0000;
    localparam logic [3:0] CODE_GO    = 4'b0001;
    localparam logic [3:0] CODE_LEFT  = 4'b0010;
    localparam logic [3:0] CODE_RIGHT = 4'b0100;
    localparam logic [3:0] CODE_BACK  = 4'b1000;

    typedef enum logic [2:0] {
        S_STOP,
        S_GO,
        S_LEFT,
        S_RIGHT,
        S_BACK,
        S_SHIFT
    } state_t;

    // The gear-change hold presents the STOP code to the lamp controller.
    function automatic logic [3:0] state_code(input state_t s);
        case (s)
            S_GO:    return CODE_GO;
            S_LEFT:  return CODE_LEFT;
            S_RIGHT: return CODE_RIGHT;
            S_BACK:  return CODE_BACK;
            default: return CODE_STOP;
        endcase
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/car_cmd_encoder_if.sv
// Key pins in, drive code and change strobe out; master is the board/key side,
// slave is the encoder.
interface car_cmd_encoder_if;
    import car_cmd_pkg::*;

    logic [NUM_KEYS-1:0] key_in;
    logic [3:0]          state_out;
    logic                cmd_chg;

    modport master (output key_in, input state_out, input cmd_chg);
    modport slave  (input key_in, output state_out, output cmd_chg);

endinterface

// File: rtl/car_cmd_encoder_debounce.sv
// One key: 2-FF synchroniser, level debounce, registered one-cycle pulse on the
// accepted press (stable 1->0). Keys are active-low and idle released (1).
module key_debounce
    import car_cmd_pkg::*;
#(
    parameter int unsigned DEB_CNT = 1_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic press
);
    localparam int unsigned   CW       = cnt_width(DEB_CNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CNT - 1);

    logic          sync_q1, sync_q2;
    logic          stable_q, stable_d;
    logic          press_q;
    logic [CW-1:0] cnt_q;

    // NOTE: every flop here uses <= so all registers sample the same pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q1  <= 1'b1;
            sync_q2  <= 1'b1;
            stable_q <= 1'b1;
            stable_d <= 1'b1;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q1  <= key_in;
            sync_q2  <= sync_q1;
            stable_d <= stable_q;
            press_q  <= stable_d & ~stable_q;
            // Any sample agreeing with the accepted level restarts the qualification window.
            if (sync_q2 == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_q <= sync_q2;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign press = press_q;

endmodule

// File: rtl/car_cmd_encoder.sv
// Turns five debounced push keys into the one-hot drive code, with a forced-STOP
// hold on GO<->BACK changes and timed auto-cancel of turn signals.
module car_cmd_encoder
    import car_cmd_pkg::*;
#(
    parameter int unsigned DEB_CNT   = 1_000_000,
    parameter int unsigned TURN_CNT  = 150_000_000,
    parameter int unsigned SHIFT_CNT = 25_000_000
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    car_cmd_encoder_if.slave cmd_if
);
    localparam int unsigned   TW         = cnt_width(TURN_CNT);
    localparam int unsigned   SW         = cnt_width(SHIFT_CNT);
    localparam logic [TW-1:0] TURN_LAST  = TW'(TURN_CNT - 1);
    localparam logic [SW-1:0] SHIFT_LAST = SW'(SHIFT_CNT - 1);

    logic [NUM_KEYS-1:0] press;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .key_in    (cmd_if.key_in[i]),
            .press     (press[i])
        );
    end

    // Priority: STOP > BACK > GO > a single turn key; LEFT+RIGHT together is dropped.
    logic   k_stop, k_back, k_go, k_turn;
    state_t turn_to;

    assign k_stop  = press[KEY_STOP];
    assign k_back  = press[KEY_BACK] & ~press[KEY_STOP];
    assign k_go    = press[KEY_GO] & ~press[KEY_BACK] & ~press[KEY_STOP];
    assign k_turn  = ~(press[KEY_STOP] | press[KEY_BACK] | press[KEY_GO])
                   & (press[KEY_LEFT] ^ press[KEY_RIGHT]);
    assign turn_to = press[KEY_LEFT] ? S_LEFT : S_RIGHT;

    state_t        state_q, state_d;
    state_t        base_q, base_d;
    state_t        target_q, target_d;
    logic          turn_restart;
    logic [TW-1:0] turn_cnt_q;
    logic [SW-1:0] shift_cnt_q;
    logic          turn_done, shift_done, in_turn_d;

    assign turn_done  = (turn_cnt_q == TURN_LAST);
    assign shift_done = (shift_cnt_q == SHIFT_LAST);
    assign in_turn_d  = (state_d == S_LEFT) || (state_d == S_RIGHT);

    always_comb begin
        // NOTE: hold-value defaults first so no path through the case infers a latch.
        state_d      = state_q;
        base_d       = base_q;
        target_d     = target_q;
        turn_restart = 1'b0;
        case (state_q)
            S_STOP: begin
                if (k_go)        state_d = S_GO;
                else if (k_back) state_d = S_BACK;
                else if (k_turn) begin
                    state_d      = turn_to;
                    base_d       = S_STOP;
                    turn_restart = 1'b1;
                end
            end
            S_GO: begin
                if (k_stop) state_d = S_STOP;
                else if (k_back) begin
                    state_d  = S_SHIFT;
                    target_d = S_BACK;
                end else if (k_turn) begin
                    state_d      = turn_to;
                    base_d       = S_GO;
                    turn_restart = 1'b1;
                end
            end
            S_BACK: begin
                if (k_stop) state_d = S_STOP;
                else if (k_go) begin
                    state_d  = S_SHIFT;
                    target_d = S_GO;
                end
            end
            S_LEFT, S_RIGHT: begin
                if (k_stop) state_d = S_STOP;
                else if (k_back) begin
                    // Reversing straight out of forward motion still needs the gear-change hold.
                    state_d  = (base_q == S_GO) ? S_SHIFT : S_BACK;
                    target_d = S_BACK;
                end else if (k_go)   state_d = S_GO;
                else if (k_turn) begin
                    state_d      = turn_to;
                    turn_restart = 1'b1;
                end else if (turn_done) state_d = base_q;
            end
            S_SHIFT: begin
                if (k_stop)          state_d = S_STOP;
                else if (shift_done) state_d = target_q;
            end
            default: state_d = S_STOP;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q          <= S_STOP;
            base_q           <= S_STOP;
            target_q         <= S_GO;
            turn_cnt_q       <= '0;
            shift_cnt_q      <= '0;
            cmd_if.state_out <= CODE_STOP;
            cmd_if.cmd_chg   <= 1'b0;
        end else begin
            state_q          <= state_d;
            base_q           <= base_d;
            target_q         <= target_d;
            turn_cnt_q       <= (in_turn_d && !turn_restart) ? turn_cnt_q + TW'(1) : '0;
            shift_cnt_q      <= (state_q == S_SHIFT && state_d == S_SHIFT) ? shift_cnt_q + SW'(1) : '0;
            cmd_if.state_out <= state_code(state_d);
            cmd_if.cmd_chg   <= (state_code(state_d) != state_code(state_q));
        end
    end

endmodule

// File: tb/tb_car_cmd_encoder.sv
// Bench for car_cmd_encoder: directed scenarios plus random key traffic, all
// cross-checked every cycle against a pin-level behavioural model.
module tb_car_cmd_encoder;
    import car_cmd_pkg::*;

    localparam int DEB_CNT   = 4;
    localparam int TURN_CNT  = 20;
    localparam int SHIFT_CNT = 8;
    localparam int TAP_HOLD  = 5;
    localparam int LAT       = 2 + DEB_CNT + 1 + 1;

    logic sys_clk;
    logic sys_rst_n;
    car_cmd_encoder_if cmd_if ();

    car_cmd_encoder #(.DEB_CNT(DEB_CNT), .TURN_CNT(TURN_CNT), .SHIFT_CNT(SHIFT_CNT)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .cmd_if    (cmd_if)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_err = 0;
    int rel [NUM_KEYS];
    bit sb_on = 1'b0;

    // Reference model: a key counts as pressed once its synchronised level has
    // disagreed with the accepted level for DEB_CNT cycles; the command takes
    // effect two cycles after acceptance. Timers count remaining cycles down.
    logic [NUM_KEYS-1:0] m_hist [DEB_CNT+2];
    logic [NUM_KEYS-1:0] m_stable, m_fell, m_pipe0, m_pipe1, ev;
    logic [3:0] m_code, m_base, m_target, m_old;
    logic       m_chg, m_shift;
    int         m_left;
    logic       e_stop, e_back, e_go, e_lt, e_rt;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int j = 0; j < DEB_CNT + 2; j++) m_hist[j] = '1;
            m_stable = '1; m_pipe0 = '0; m_pipe1 = '0;
            m_code = CODE_STOP; m_chg = 1'b0; m_shift = 1'b0; m_left = 0;
            m_base = CODE_STOP; m_target = CODE_GO;
        end else begin
            for (int j = DEB_CNT + 1; j > 0; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = cmd_if.key_in;
            m_fell = '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                automatic bit diff = 1'b1;
                for (int j = 2; j < DEB_CNT + 2; j++)
                    if (m_hist[j][i] == m_stable[i]) diff = 1'b0;
                if (diff) begin
                    m_stable[i] = ~m_stable[i];
                    if (!m_stable[i]) m_fell[i] = 1'b1;
                end
            end
            ev = m_pipe1; m_pipe1 = m_pipe0; m_pipe0 = m_fell;
            e_stop = ev[KEY_STOP];
            e_back = ev[KEY_BACK] && !e_stop;
            e_go   = ev[KEY_GO] && !e_stop && !ev[KEY_BACK];
            e_lt   = !ev[KEY_STOP] && !ev[KEY_BACK] && !ev[KEY_GO] && ev[KEY_LEFT] && !ev[KEY_RIGHT];
            e_rt   = !ev[KEY_STOP] && !ev[KEY_BACK] && !ev[KEY_GO] && ev[KEY_RIGHT] && !ev[KEY_LEFT];
            m_old = m_code;
            if (m_shift) begin
                if (e_stop) m_shift = 1'b0;
                else if (m_left == 0) begin m_shift = 1'b0; m_code = m_target; end
                else m_left--;
            end else if (m_code == CODE_STOP) begin
                if (e_go) m_code = CODE_GO;
                else if (e_back) m_code = CODE_BACK;
                else if (e_lt || e_rt) begin
                    m_code = e_lt ? CODE_LEFT : CODE_RIGHT; m_base = CODE_STOP; m_left = TURN_CNT - 1;
                end
            end else if (m_code == CODE_GO) begin
                if (e_stop) m_code = CODE_STOP;
                else if (e_back) begin
                    m_shift = 1'b1; m_target = CODE_BACK; m_left = SHIFT_CNT - 1; m_code = CODE_STOP;
                end else if (e_lt || e_rt) begin
                    m_code = e_lt ? CODE_LEFT : CODE_RIGHT; m_base = CODE_GO; m_left = TURN_CNT - 1;
                end
            end else if (m_code == CODE_BACK) begin
                if (e_stop) m_code = CODE_STOP;
                else if (e_go) begin
                    m_shift = 1'b1; m_target = CODE_GO; m_left = SHIFT_CNT - 1; m_code = CODE_STOP;
                end
            end else begin
                if (e_stop) m_code = CODE_STOP;
                else if (e_back) begin
                    if (m_base == CODE_GO) begin
                        m_shift = 1'b1; m_target = CODE_BACK; m_left = SHIFT_CNT - 1; m_code = CODE_STOP;
                    end else m_code = CODE_BACK;
                end else if (e_go) m_code = CODE_GO;
                else if (e_lt || e_rt) begin
                    m_code = e_lt ? CODE_LEFT : CODE_RIGHT; m_left = TURN_CNT - 1;
                end else if (m_left == 0) m_code = m_base;
                else m_left--;
            end
            m_chg = (m_code != m_old);
        end
    end

    always @(negedge sys_clk) begin
        if (sb_on) begin
            n_cmp++;
            if (cmd_if.state_out !== m_code || cmd_if.cmd_chg !== m_chg) begin
                n_err++;
                if (n_err <= 20)
                    $display("FAIL model_cycle t=%0t: state_out=%b cmd_chg=%b, model wants %b/%b",
                             $time, cmd_if.state_out, cmd_if.cmd_chg, m_code, m_chg);
            end
        end
    end

    task tick();
        @(negedge sys_clk);
        for (int i = 0; i < NUM_KEYS; i++)
            if (rel[i] > 0) begin
                rel[i]--;
                if (rel[i] == 0) cmd_if.key_in[i] = 1'b1;
            end
    endtask

    task tap(input logic [NUM_KEYS-1:0] mask);
        for (int i = 0; i < NUM_KEYS; i++)
            if (mask[i]) begin
                cmd_if.key_in[i] = 1'b0;
                rel[i] = TAP_HOLD;
            end
    endtask

    task automatic wait_change(input int max_cyc, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (cmd_if.cmd_chg !== 1'b1 && n < max_cyc);
    endtask

    task test_reset();
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        n_cmp++;
        if (cmd_if.state_out !== CODE_STOP || cmd_if.cmd_chg !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: state_out=%b cmd_chg=%b, required 0000/0", cmd_if.state_out, cmd_if.cmd_chg);
        end
        #2 sys_rst_n = 1'b1;
        sb_on = 1'b1;
        repeat (4) tick();
        n_cmp++;
        if (cmd_if.state_out !== CODE_STOP || cmd_if.cmd_chg !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: state_out=%b cmd_chg=%b, required 0000/0", cmd_if.state_out, cmd_if.cmd_chg);
        end
    endtask

    task test_go_debounce();
        int n;
        bit extra;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 3; c++) begin
                cmd_if.key_in[KEY_GO] = (c == 2);
                tick();
                n_cmp++;
                if (cmd_if.state_out !== CODE_STOP || cmd_if.cmd_chg !== 1'b0) begin
                    n_err++;
                    $display("FAIL glitch_rejected: state_out=%b cmd_chg=%b, required 0000/0",
                             cmd_if.state_out, cmd_if.cmd_chg);
                end
            end
        cmd_if.key_in[KEY_GO] = 1'b0;
        wait_change(30, n);
        n_cmp++;
        if (n !== LAT || cmd_if.state_out !== CODE_GO) begin
            n_err++;
            $display("FAIL go_press: latency %0d state_out %b, required %0d / 0001", n, cmd_if.state_out, LAT);
        end
        extra = 1'b0;
        repeat (30) begin
            tick();
            if (cmd_if.cmd_chg !== 1'b0 || cmd_if.state_out !== CODE_GO) extra = 1'b1;
        end
        n_cmp++;
        if (extra) begin
            n_err++;
            $display("FAIL go_held_once: repeat activity while held, state_out=%b, required steady 0001", cmd_if.state_out);
        end
        cmd_if.key_in[KEY_GO] = 1'b1;
        repeat (12) tick();
    endtask

    task automatic expect_change(input string name, input int max_cyc, input int lat, input logic [3:0] code);
        int n;
        wait_change(max_cyc, n);
        n_cmp++;
        if (n !== lat || cmd_if.state_out !== code) begin
            n_err++;
            $display("FAIL %s: after %0d cycles state_out=%b cmd_chg=%b, required %0d cycles / %b",
                     name, n, cmd_if.state_out, cmd_if.cmd_chg, lat, code);
        end
    endtask

    task test_shift();
        tap(1 << KEY_BACK);
        expect_change("go_to_shift", 20, LAT, CODE_STOP);
        expect_change("shift_to_back", 20, SHIFT_CNT, CODE_BACK);
        tap(1 << KEY_STOP);
        expect_change("back_to_stop", 20, LAT, CODE_STOP);
        tap(1 << KEY_GO);
        expect_change("stop_to_go", 20, LAT, CODE_GO);
        tap(1 << KEY_BACK);
        repeat (2) tick();
        tap(1 << KEY_STOP);
        expect_change("abort_enter_shift", 20, LAT - 2, CODE_STOP);
        expect_change("shift_aborted", 25, 25, CODE_STOP);
    endtask

    task test_turn();
        tap(1 << KEY_GO);
        expect_change("turn_setup_go", 20, LAT, CODE_GO);
        tap(1 << KEY_LEFT);
        expect_change("left_on", 20, LAT, CODE_LEFT);
        expect_change("left_timeout", 40, TURN_CNT, CODE_GO);
        tap(1 << KEY_LEFT);
        expect_change("left_again", 20, LAT, CODE_LEFT);
        repeat (15 - LAT) tick();
        tap(1 << KEY_LEFT);
        expect_change("left_restart", 60, LAT + TURN_CNT, CODE_GO);
        tap(1 << KEY_LEFT);
        expect_change("left_third", 20, LAT, CODE_LEFT);
        repeat (5) tick();
        tap(1 << KEY_RIGHT);
        expect_change("switch_right", 20, LAT, CODE_RIGHT);
        expect_change("right_timeout", 40, TURN_CNT, CODE_GO);
    endtask

    task test_simultaneous();
        tap(1 << KEY_STOP);
        expect_change("sim_setup_stop", 20, LAT, CODE_STOP);
        tap((1 << KEY_LEFT) | (1 << KEY_RIGHT));
        expect_change("left_right_ignored", 25, 25, CODE_STOP);
        tap((1 << KEY_STOP) | (1 << KEY_GO));
        expect_change("stop_beats_go", 25, 25, CODE_STOP);
    endtask

    task test_back();
        tap(1 << KEY_BACK);
        expect_change("stop_to_back", 20, LAT, CODE_BACK);
        tap(1 << KEY_LEFT);
        expect_change("no_turn_in_back", 25, 25, CODE_BACK);
        tap(1 << KEY_GO);
        expect_change("back_to_shift", 20, LAT, CODE_STOP);
        expect_change("shift_to_go", 20, SHIFT_CNT, CODE_GO);
    endtask

    task automatic pulse_reset(input string name);
        #2 sys_rst_n = 1'b0;
        #1;
        n_cmp++;
        if (cmd_if.state_out !== CODE_STOP || cmd_if.cmd_chg !== 1'b0) begin
            n_err++;
            $display("FAIL %s: state_out=%b cmd_chg=%b right after reset, required 0000/0",
                     name, cmd_if.state_out, cmd_if.cmd_chg);
        end
        repeat (2) tick();
        #2 sys_rst_n = 1'b1;
    endtask

    task test_reset_mid();
        tap(1 << KEY_BACK);
        expect_change("rst_enter_shift", 20, LAT, CODE_STOP);
        pulse_reset("reset_in_shift");
        expect_change("no_back_after_reset", 20, 20, CODE_STOP);
        tap(1 << KEY_GO);
        expect_change("rst2_go", 20, LAT, CODE_GO);
        tap(1 << KEY_LEFT);
        expect_change("rst2_left", 20, LAT, CODE_LEFT);
        repeat (5) tick();
        pulse_reset("reset_in_turn");
        expect_change("stay_stop_after_reset", 30, 30, CODE_STOP);
        tap(1 << KEY_GO);
        expect_change("fresh_go", 20, LAT, CODE_GO);
    endtask

    task test_random();
        logic [NUM_KEYS-1:0] v;
        int r;
        repeat (20) tick();
        for (int i = 0; i < NUM_KEYS; i++) rel[i] = 0;
        for (int s = 0; s < 90; s++) begin
            v = '1;
            r = $urandom_range(0, 9);
            if (r < 6) v[$urandom_range(0, NUM_KEYS - 1)] = 1'b0;
            else if (r < 8) begin
                v[$urandom_range(0, NUM_KEYS - 1)] = 1'b0;
                v[$urandom_range(0, NUM_KEYS - 1)] = 1'b0;
            end
            cmd_if.key_in = v;
            repeat ($urandom_range(1, 14)) tick();
        end
        cmd_if.key_in = '1;
        repeat (40) tick();
    endtask

    initial begin
        sys_rst_n = 1'b0;
        cmd_if.key_in = '1;
        for (int i = 0; i < NUM_KEYS; i++) rel[i] = 0;
        test_reset();
        test_go_debounce();
        test_shift();
        test_turn();
        test_simultaneous();
        test_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish within 500000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
